// File: rtl/barrel_rotator_left_pipe.sv
// Pipelined left rotator, one stage per amount bit, SHIFT_W cycles latency.
// Valid/ready on both sides; stalls ripple back combinationally and empty stages keep filling.
module barrel_rotator_left_pipe #(
  parameter int WIDTH = 8,
  localparam int SHIFT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               inValid,
  output logic               inReady,
  input  logic [WIDTH-1:0]   a,
  input  logic [SHIFT_W-1:0] shiftAmount,
  output logic               outValid,
  input  logic               outReady,
  output logic [WIDTH-1:0]   shifted
);

  logic [SHIFT_W-1:0] vld;
  logic [SHIFT_W-1:0] adv;
  logic [WIDTH-1:0]   dat [SHIFT_W];
  logic [SHIFT_W-1:0] amt [SHIFT_W];

  // A stage may load when it is empty or the stage after it is moving.
  always_comb begin
    logic nxt;
    adv = '0;
    nxt = outReady;
    for (int k = SHIFT_W - 1; k >= 0; k--) begin
      nxt    = !vld[k] || nxt;
      adv[k] = nxt;
    end
  end

  for (genvar k = 0; k < SHIFT_W; k++) begin : g_stage
    localparam int S = 1 << k;

    logic               src_vld;
    logic [WIDTH-1:0]   src_dat;
    logic [SHIFT_W-1:0] src_amt;
    logic [WIDTH-1:0]   rot_dat;

    if (k == 0) begin : g_head
      assign src_vld = inValid;
      assign src_dat = a;
      assign src_amt = shiftAmount;
    end else begin : g_body
      assign src_vld = vld[k-1];
      assign src_dat = dat[k-1];
      assign src_amt = amt[k-1];
    end

    assign rot_dat = src_amt[k] ? {src_dat[WIDTH-1-S:0], src_dat[WIDTH-1:WIDTH-S]} : src_dat;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        vld[k] <= 1'b0;
        dat[k] <= '0;
        amt[k] <= '0;
      end else if (adv[k]) begin
        vld[k] <= src_vld;
        if (src_vld) begin
          dat[k] <= rot_dat;
          amt[k] <= src_amt;
        end
      end
    end
  end

  assign inReady  = adv[0];
  assign outValid = vld[SHIFT_W-1];
  assign shifted  = dat[SHIFT_W-1];

endmodule

// File: tb/tb_barrel_rotator_left_pipe.sv
// Scoreboard bench for barrel_rotator_left_pipe (WIDTH=8).
module tb_barrel_rotator_left_pipe;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       inValid;
  logic       inReady;
  logic [7:0] a;
  logic [2:0] shiftAmount;
  logic       outValid;
  logic       outReady;
  logic [7:0] shifted;

  int n_cmp = 0;
  int n_err = 0;
  int n_acc = 0;
  int n_out = 0;
  int cyc   = 0;

  logic [7:0] q [$];
  logic [7:0] cur_exp;
  logic       hold_vld = 1'b0;
  logic [7:0] hold_dat;

  barrel_rotator_left_pipe #(.WIDTH(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .inValid(inValid), .inReady(inReady), .a(a), .shiftAmount(shiftAmount),
    .outValid(outValid), .outReady(outReady), .shifted(shifted)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] rotl(input logic [7:0] d, input logic [2:0] n);
    logic [15:0] t;
    t = {d, d} << n;
    return t[15:8];
  endfunction

  function automatic logic [7:0] rotr(input logic [7:0] d, input logic [2:0] n);
    logic [15:0] t;
    t = {d, d} >> n;
    return t[7:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Handshakes are evaluated mid-cycle, where they are settled for the coming edge.
  always @(negedge clk) begin
    if (!reset_n) begin
      hold_vld = 1'b0;
    end else begin
      if (hold_vld) begin
        chk("hold_vld", outValid, 1);
        chk("hold_dat", shifted, hold_dat);
      end
      if (outValid && outReady) begin
        if (q.size() == 0) chk("spurious", q.size(), 1);
        else chk("data", shifted, q.pop_front());
        n_out++;
      end
      if (inValid && inReady) begin
        q.push_back(cur_exp);
        n_acc++;
      end
      hold_vld = outValid && !outReady;
      hold_dat = shifted;
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [7:0] d, input logic [2:0] n, input logic [7:0] e,
                      input int budget, output bit ok);
    a = d; shiftAmount = n; cur_exp = e; inValid = 1'b1; ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (inReady) ok = 1'b1;
      @(posedge clk); #1;
    end
    inValid = 1'b0;
  endtask

  task automatic send_chk(input logic [7:0] d, input logic [2:0] n, input logic [7:0] e);
    bit ok;
    send(d, n, e, 200, ok);
    if (!ok) chk("send_timeout", ok, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && q.size() > 0; i++) begin
      @(posedge clk); #1;
    end
    chk("drain_empty", q.size(), 0);
  endtask

  initial begin
    bit ok;
    int lat, t0, n0, acc0;
    logic [7:0] d;
    logic [2:0] n;
    logic done;

    reset_n = 1'b0; inValid = 1'b0; outReady = 1'b0; a = '0; shiftAmount = '0; cur_exp = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outValid", outValid, 0);
    chk("rst_shifted", shifted, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_inReady", inReady, 1);

    // Test 1: single word, latency
    outReady = 1'b1;
    send_chk(8'hB4, 3'd3, 8'hA5);
    lat = 1;
    while (!outValid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, 3);
    chk("t1_shifted", shifted, 8'hA5);
    drain();

    // Test 2: boundary vectors
    send_chk(8'h81, 3'd0, 8'h81);
    send_chk(8'h01, 3'd7, 8'h80);
    send_chk(8'h80, 3'd1, 8'h01);
    drain();

    // Test 3: back-to-back stream, rotr then this block restores the word
    n0 = n_out;
    t0 = cyc;
    for (int i = 0; i < 256; i++) begin
      d = 8'($urandom);
      n = 3'($urandom);
      send_chk(rotr(d, n), n, d);
    end
    chk("stream_cycles", cyc - t0, 256);
    drain();
    chk("stream_count", n_out - n0, 256);

    // Test 4: stall fills three stages then backpressures
    outReady = 1'b0;
    acc0 = n_acc;
    for (int i = 0; i < 5; i++) begin
      d = 8'($urandom);
      n = 3'($urandom);
      send(d, n, rotl(d, n), 4, ok);
      if (!ok) break;
    end
    chk("stall_accepted", n_acc - acc0, 3);
    chk("stall_inReady", inReady, 0);
    chk("stall_outValid", outValid, 1);
    chk("stall_head", shifted, q[0]);
    outReady = 1'b1;
    #1;
    chk("release_inReady", inReady, 1);
    drain();

    // Test 5: random valid/ready toggling
    n0 = n_out;
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          repeat ($urandom_range(1, 0)) begin @(posedge clk); #1; end
          d = 8'($urandom);
          n = 3'($urandom);
          send_chk(d, n, rotl(d, n));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          outReady = 1'($urandom);
        end
      end
    join
    outReady = 1'b1;
    drain();
    chk("random_count", n_out - n0, 1000);

    // Test 6: reset with words in flight
    outReady = 1'b0;
    for (int i = 0; i < 3; i++) send_chk(8'(i + 8'h11), 3'(i + 1), rotl(8'(i + 8'h11), 3'(i + 1)));
    #1;
    reset_n = 1'b0;
    #1;
    chk("arst_outValid", outValid, 0);
    chk("arst_shifted", shifted, 0);
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    outReady = 1'b1;
    n0 = n_out;
    send_chk(8'h0F, 3'd4, 8'hF0);
    repeat (10) @(posedge clk);
    #1;
    chk("post_rst_count", n_out - n0, 1);
    chk("post_rst_q", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
